// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: credit-limited request issue to instruction memory,
// an in-order response FIFO towards decode, and redirect/halt handling with response dropping.
module fetch_prefetch #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [WIDTH-1:0]         imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [WIDTH-1:0]         imem_rsp_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [WIDTH-1:0]         instr_out,
    output logic [WIDTH-1:0]         pc_out,
    output logic [WIDTH-1:0]         pcPlus4,
    input  logic                     pc_src,
    input  logic [WIDTH-1:0]         jump_val,
    input  logic                     pc_halt,
    output logic [$clog2(DEPTH):0]   buf_count
);

    localparam int unsigned      AW      = $clog2(DEPTH);
    localparam int unsigned      CW      = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE_C   = CW'(1);
    localparam logic [CW-1:0]    ZERO_C  = {CW{1'b0}};
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] pc_mem_q   [DEPTH];
    logic [WIDTH-1:0] data_mem_q [DEPTH];

    logic [CW:0]      credit_use_s;
    logic             req_hs_s;
    logic             push_s;
    logic             pop_s;

    // Buffered entries plus responses still expected to land bound new requests.
    assign credit_use_s   = {1'b0, count_q} + {1'b0, outstanding_q - drop_cnt_q};
    assign imem_req_valid = rst & ~pc_src & ~pc_halt
                          & (credit_use_s < {1'b0, DEPTH_C}) & (outstanding_q < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_hs_s       = imem_req_valid & imem_req_ready;
    assign push_s         = imem_rsp_valid & ~pc_src & (drop_cnt_q == ZERO_C);
    assign pop_s          = instr_valid & instr_ready & ~pc_src;

    assign buf_count      = count_q;
    assign instr_valid    = (count_q != ZERO_C);
    assign instr_out      = instr_valid ? data_mem_q[rd_ptr_q] : {WIDTH{1'b0}};
    assign pc_out         = instr_valid ? pc_mem_q[rd_ptr_q] : {WIDTH{1'b0}};
    assign pcPlus4        = instr_valid ? (pc_mem_q[rd_ptr_q] + PC_STEP) : {WIDTH{1'b0}};

    // Next-state for PCs, credit counters and FIFO pointers; a redirect overrides everything else.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (pc_src) begin
            fetch_pc_d    = jump_val;
            rsp_pc_d      = jump_val;
            outstanding_d = outstanding_q - (imem_rsp_valid ? ONE_C : ZERO_C);
            drop_cnt_d    = outstanding_q - (imem_rsp_valid ? ONE_C : ZERO_C);
            count_d       = ZERO_C;
            rd_ptr_d      = {AW{1'b0}};
            wr_ptr_d      = {AW{1'b0}};
        end else begin
            fetch_pc_d    = req_hs_s ? (fetch_pc_q + PC_STEP) : fetch_pc_q;
            outstanding_d = outstanding_q + (req_hs_s ? ONE_C : ZERO_C)
                          - (imem_rsp_valid ? ONE_C : ZERO_C);
            if (imem_rsp_valid && (drop_cnt_q != ZERO_C)) begin
                drop_cnt_d = drop_cnt_q - ONE_C;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end else begin
                wr_ptr_d = wr_ptr_q;
                rsp_pc_d = rsp_pc_q;
            end
            rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            count_d  = count_q + (push_s ? ONE_C : ZERO_C) - (pop_s ? ONE_C : ZERO_C);
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= ZERO_C;
            drop_cnt_q    <= ZERO_C;
            count_q       <= ZERO_C;
            rd_ptr_q      <= {AW{1'b0}};
            wr_ptr_q      <= {AW{1'b0}};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only visible while count_q says the slot is live.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
            data_mem_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model and an in-order memory model.
module tb_fetch_prefetch;

    localparam int          W   = 32;
    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pcPlus4;
    logic        pc_src;
    logic [31:0] jump_val;
    logic        pc_halt;
    logic [2:0]  buf_count;

    fetch_prefetch #(.WIDTH(W), .DEPTH(D), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .pc_out(pc_out), .pcPlus4(pcPlus4),
        .pc_src(pc_src), .jump_val(jump_val), .pc_halt(pc_halt),
        .buf_count(buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    int mem_lat  = 1;
    bit rand_lat = 1'b0;
    int last_due = -1;

    // memory model: in-order responses, each due at a given cycle
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    // reference model: buffered (pc, data) pairs and credit bookkeeping
    logic [31:0] m_fpc[$];
    logic [31:0] m_fdat[$];
    logic [31:0] m_fetch;
    logic [31:0] m_rsp;
    int          m_out;
    int          m_drop;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_9E01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%h expected 0x%h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"},   {31'd0, imem_req_valid}, 32'd0);
        chk({tag, "_req_addr"},    imem_req_addr, RPC);
        chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_buf_count"},   {29'd0, buf_count}, 32'd0);
        chk({tag, "_instr_out"},   instr_out, 32'd0);
        chk({tag, "_pc_out"},      pc_out, 32'd0);
        chk({tag, "_pcplus4"},     pcPlus4, 32'd0);
    endtask

    // Assert reset (possibly mid-cycle), check async outputs, release just after an edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        imem_rsp_valid = 1'b0;
        pc_src = 1'b0;
        pc_halt = 1'b0;
        #1;
        chk_reset_outputs(tag);
        m_fpc.delete(); m_fdat.delete(); mq_addr.delete(); mq_due.delete();
        m_fetch = RPC; m_rsp = RPC; m_out = 0; m_drop = 0;
        last_due = -1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model and memory.
    task automatic cycle(input bit src, input logic [31:0] jv, input bit halt,
                         input bit mrdy, input bit irdy);
        bit          rv;
        logic [31:0] rd;
        bit          exp_rv;
        bit          exp_iv;
        int          used;
        int          due;
        pc_src = src; jump_val = jv; pc_halt = halt;
        imem_req_ready = mrdy; instr_ready = irdy;
        rv = 1'b0;
        rd = $urandom();
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            rv = 1'b1;
            rd = mem_word(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        #2;
        used   = m_fpc.size() + m_out - m_drop;
        exp_rv = !src && !halt && (used < D) && (m_out < D);
        exp_iv = (m_fpc.size() != 0);
        chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        chk("req_addr", imem_req_addr, m_fetch);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_iv});
        chk("buf_count", {29'd0, buf_count}, 32'(m_fpc.size()));
        chk("instr_out", instr_out, exp_iv ? m_fdat[0] : 32'd0);
        chk("pc_out", pc_out, exp_iv ? m_fpc[0] : 32'd0);
        chk("pcplus4", pcPlus4, exp_iv ? (m_fpc[0] + 32'd4) : 32'd0);
        if (imem_req_valid && mrdy) begin
            hs_cnt++;
            due = cyc + (rand_lat ? int'($urandom_range(3, 1)) : mem_lat);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
        end
        if (src) begin
            m_fpc.delete(); m_fdat.delete();
            m_drop  = m_out - int'(rv);
            m_out   = m_out - int'(rv);
            m_fetch = jv;
            m_rsp   = jv;
        end else begin
            if (exp_iv && irdy) begin
                void'(m_fpc.pop_front());
                void'(m_fdat.pop_front());
            end
            if (exp_rv && mrdy) begin
                m_fetch = m_fetch + 32'd4;
                m_out++;
            end
            if (rv) begin
                m_out--;
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    m_fpc.push_back(m_rsp);
                    m_fdat.push_back(rd);
                    m_rsp = m_rsp + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int hs0;
        rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        instr_ready = 1'b0; pc_src = 1'b0; jump_val = 32'd0; pc_halt = 1'b0;
        #3;
        do_reset("por");

        // streaming: one instruction per cycle from cycle 2, pc 0,4,8,...
        mem_lat = 1;
        for (int k = 0; k < 12; k++) begin
            if (k >= 2) begin
                chk("stream_valid", {31'd0, instr_valid}, 32'd1);
                chk("stream_pc", pc_out, 32'(4 * (k - 2)));
            end
            cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        end

        // backpressure: exactly 4 requests, then one pop frees exactly one credit
        do_reset("bp");
        hs0 = hs_cnt;
        for (int k = 0; k < 10; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("bp_requests", 32'(hs_cnt - hs0), 32'd4);
        chk("bp_full", {29'd0, buf_count}, 32'd4);
        chk("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
        hs0 = hs_cnt;
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("bp_one_more", 32'(hs_cnt - hs0), 32'd1);

        // asynchronous reset with a full buffer
        do_reset("midop");

        // redirect with three requests in flight (latency 3)
        mem_lat = 3;
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 20 && !instr_valid; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        chk("redir_first_pc", pc_out, 32'h0000_0100);
        chk("redir_first_data", instr_out, mem_word(32'h0000_0100));
        for (int k = 0; k < 6; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

        // redirect coinciding with a response and a decode pop
        do_reset("rdr2");
        mem_lat = 1;
        for (int k = 0; k < 5; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0200, 1'b0, 1'b1, 1'b1);
        chk("rdr2_flushed", {29'd0, buf_count}, 32'd0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

        // halt with two requests outstanding, then resume at the held PC
        do_reset("halt");
        mem_lat = 2;
        hs0 = hs_cnt;
        for (int k = 0; k < 2; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        chk("halt_requests", 32'(hs_cnt - hs0), 32'd2);
        chk("halt_buffered", {29'd0, buf_count}, 32'd2);
        chk("halt_held_pc", imem_req_addr, 32'h0000_0008);
        for (int k = 0; k < 4; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

        // address wrap around 2^32
        cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);

        // randomized traffic with variable memory latency
        do_reset("rnd");
        rand_lat = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(15, 0) == 0),
                  ($urandom() & 32'hFFFF_FFFC),
                  ($urandom_range(7, 0) == 0),
                  ($urandom_range(3, 0) != 0),
                  ($urandom_range(2, 0) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
